// File: rtl/dmem_arbiter.sv
// Round-robin arbiter and sequencer sharing one DRAM port between the CPU MEM stage (M0)
// and the loader/debug requester (M1); stalls the CPU while an M0 access is outstanding.
module dmem_arbiter #(
  parameter int AW        = 32,
  parameter int DW        = 32,
  parameter int RD_LAT    = 1,
  parameter int MEM_WORDS = 16384
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_m0_req,
  input  logic          i_m0_we,
  input  logic [AW-1:0] i_m0_addr,
  input  logic [DW-1:0] i_m0_wdata,
  output logic          o_m0_ack,
  output logic          o_m0_err,
  output logic [DW-1:0] o_m0_rdata,
  input  logic          i_m1_req,
  input  logic          i_m1_we,
  input  logic [AW-1:0] i_m1_addr,
  input  logic [DW-1:0] i_m1_wdata,
  output logic          o_m1_ack,
  output logic          o_m1_err,
  output logic [DW-1:0] o_m1_rdata,
  output logic          o_dram_en,
  output logic          o_dram_we,
  output logic [AW-1:0] o_dram_addr,
  output logic [DW-1:0] o_dram_wdata,
  input  logic [DW-1:0] i_dram_rdata,
  output logic          o_cpu_stall,
  output logic          o_busy
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_WAIT   = 2'd2,
    ST_RESP   = 2'd3
  } state_t;

  // One extra bit keeps MEM_WORDS*4 from wrapping at the top of the address space.
  localparam logic [AW:0] LP_MEM_BYTES = (AW+1)'(MEM_WORDS) << 2'd2;
  localparam logic [2:0]  LP_CNT_INIT  = 3'(RD_LAT - 1);

  function automatic logic addr_bad(input logic [AW-1:0] a);
    return (a[1:0] != 2'b00) || ({1'b0, a} >= LP_MEM_BYTES);
  endfunction

  state_t        r_state;
  state_t        w_state_nxt;
  logic          r_ptr;
  logic          r_id;
  logic          r_we;
  logic [2:0]    r_cnt;
  logic          r_m0_ack;
  logic          r_m0_err;
  logic [DW-1:0] r_m0_rdata;
  logic          r_m1_ack;
  logic          r_m1_err;
  logic [DW-1:0] r_m1_rdata;
  logic          r_dram_en;
  logic          r_dram_we;
  logic [AW-1:0] r_dram_addr;
  logic [DW-1:0] r_dram_wdata;

  logic          w_gnt_vld;
  logic          w_gnt_id;
  logic          w_sel_we;
  logic [AW-1:0] w_sel_addr;
  logic [DW-1:0] w_sel_wdata;
  logic          w_sel_bad;

  // Arbitration: a lone requester wins, contention goes to the round-robin pointer.
  always_comb begin
    w_gnt_vld = i_m0_req | i_m1_req;
    if (i_m0_req && i_m1_req) begin
      w_gnt_id = r_ptr;
    end else if (i_m1_req) begin
      w_gnt_id = 1'b1;
    end else begin
      w_gnt_id = 1'b0;
    end
    if (w_gnt_id) begin
      w_sel_we    = i_m1_we;
      w_sel_addr  = i_m1_addr;
      w_sel_wdata = i_m1_wdata;
    end else begin
      w_sel_we    = i_m0_we;
      w_sel_addr  = i_m0_addr;
      w_sel_wdata = i_m0_wdata;
    end
    w_sel_bad = addr_bad(w_sel_addr);
  end

  // Next-state logic for the access sequencer.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_gnt_vld) begin
          w_state_nxt = w_sel_bad ? ST_RESP : ST_ACCESS;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_ACCESS: w_state_nxt = r_we ? ST_RESP : ST_WAIT;
      ST_WAIT: begin
        if (r_cnt == 3'd0) begin
          w_state_nxt = ST_RESP;
        end else begin
          w_state_nxt = ST_WAIT;
        end
      end
      ST_RESP: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Datapath: grant latching, DRAM strobes, latency count, read capture and ack pulses.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_ptr        <= 1'b0;
      r_id         <= 1'b0;
      r_we         <= 1'b0;
      r_cnt        <= 3'd0;
      r_m0_ack     <= 1'b0;
      r_m0_err     <= 1'b0;
      r_m0_rdata   <= {DW{1'b0}};
      r_m1_ack     <= 1'b0;
      r_m1_err     <= 1'b0;
      r_m1_rdata   <= {DW{1'b0}};
      r_dram_en    <= 1'b0;
      r_dram_we    <= 1'b0;
      r_dram_addr  <= {AW{1'b0}};
      r_dram_wdata <= {DW{1'b0}};
    end else begin
      r_dram_en <= 1'b0;
      r_dram_we <= 1'b0;
      r_m0_ack  <= 1'b0;
      r_m0_err  <= 1'b0;
      r_m1_ack  <= 1'b0;
      r_m1_err  <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_gnt_vld) begin
            r_id  <= w_gnt_id;
            r_we  <= w_sel_we;
            r_ptr <= ~w_gnt_id;
            if (w_sel_bad) begin
              // Rejected accesses answer immediately with a cleared read register.
              if (w_gnt_id) begin
                r_m1_ack   <= 1'b1;
                r_m1_err   <= 1'b1;
                r_m1_rdata <= {DW{1'b0}};
              end else begin
                r_m0_ack   <= 1'b1;
                r_m0_err   <= 1'b1;
                r_m0_rdata <= {DW{1'b0}};
              end
            end else begin
              r_dram_en    <= 1'b1;
              r_dram_we    <= w_sel_we;
              r_dram_addr  <= w_sel_addr;
              r_dram_wdata <= w_sel_wdata;
            end
          end
        end
        ST_ACCESS: begin
          if (r_we) begin
            r_m0_ack <= ~r_id;
            r_m1_ack <= r_id;
          end else begin
            r_cnt <= LP_CNT_INIT;
          end
        end
        ST_WAIT: begin
          if (r_cnt == 3'd0) begin
            if (r_id) begin
              r_m1_rdata <= i_dram_rdata;
              r_m1_ack   <= 1'b1;
            end else begin
              r_m0_rdata <= i_dram_rdata;
              r_m0_ack   <= 1'b1;
            end
          end else begin
            r_cnt <= r_cnt - 3'd1;
          end
        end
        ST_RESP: begin
          r_cnt <= 3'd0;
        end
        default: begin
          r_cnt <= 3'd0;
        end
      endcase
    end
  end

  assign o_m0_ack     = r_m0_ack;
  assign o_m0_err     = r_m0_err;
  assign o_m0_rdata   = r_m0_rdata;
  assign o_m1_ack     = r_m1_ack;
  assign o_m1_err     = r_m1_err;
  assign o_m1_rdata   = r_m1_rdata;
  assign o_dram_en    = r_dram_en;
  assign o_dram_we    = r_dram_we;
  assign o_dram_addr  = r_dram_addr;
  assign o_dram_wdata = r_dram_wdata;
  assign o_cpu_stall  = i_m0_req & ~r_m0_ack;
  assign o_busy       = (r_state != ST_IDLE);

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: directed latency/arbitration/reset cases plus
// randomized traffic from both masters against a word-level memory model.
module tb_dmem_arbiter;
  localparam int AW        = 32;
  localparam int DW        = 32;
  localparam int RD_LAT    = 3;
  localparam int MEM_WORDS = 16384;
  localparam int NSLOT     = 66;

  typedef struct {
    logic        err;
    logic        rd;
    logic [31:0] rdata;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_d [2];
  logic        we_d [2];
  logic [31:0] addr_d [2];
  logic [31:0] wdata_d [2];
  logic        o_m0_ack, o_m0_err, o_m1_ack, o_m1_err;
  logic [31:0] o_m0_rdata, o_m1_rdata;
  logic        o_dram_en, o_dram_we, o_cpu_stall, o_busy;
  logic [31:0] o_dram_addr, o_dram_wdata, dram_rdata;

  exp_t        q [2][$];
  logic [31:0] mdl_rdata [2];
  logic [31:0] ref_mem [NSLOT];
  logic [31:0] dmem [NSLOT];
  logic [31:0] pd [RD_LAT];
  logic        pv [RD_LAT];
  int          total = 0;
  int          bad = 0;
  int          ack_cnt [2];
  int          en_cnt = 0;
  int          ack_log [$];
  bit          log_en = 1'b0;

  always #5 clk = ~clk;

  dmem_arbiter #(.AW(AW), .DW(DW), .RD_LAT(RD_LAT), .MEM_WORDS(MEM_WORDS)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_m0_req(req_d[0]), .i_m0_we(we_d[0]), .i_m0_addr(addr_d[0]), .i_m0_wdata(wdata_d[0]),
    .o_m0_ack(o_m0_ack), .o_m0_err(o_m0_err), .o_m0_rdata(o_m0_rdata),
    .i_m1_req(req_d[1]), .i_m1_we(we_d[1]), .i_m1_addr(addr_d[1]), .i_m1_wdata(wdata_d[1]),
    .o_m1_ack(o_m1_ack), .o_m1_err(o_m1_err), .o_m1_rdata(o_m1_rdata),
    .o_dram_en(o_dram_en), .o_dram_we(o_dram_we), .o_dram_addr(o_dram_addr),
    .o_dram_wdata(o_dram_wdata), .i_dram_rdata(dram_rdata),
    .o_cpu_stall(o_cpu_stall), .o_busy(o_busy)
  );

  function automatic int slot_of(input logic [31:0] a);
    int w;
    w = int'(a[31:2]);
    if (w < 64) return w;
    if (w == 16382) return 64;
    if (w == 16383) return 65;
    return 0;
  endfunction

  function automatic logic [31:0] init_word(input int s);
    return 32'h5A00_0000 ^ (32'(s) * 32'h0001_0203);
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp_v);
    total++;
    if (act !== exp_v) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp_v);
    end
  endtask

  // DRAM model: writes land at the edge, reads appear RD_LAT cycles after the strobe
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < RD_LAT; i++) pv[i] <= 1'b0;
    end else begin
      pv[0] <= o_dram_en && !o_dram_we;
      pd[0] <= dmem[slot_of(o_dram_addr)];
      for (int i = 1; i < RD_LAT; i++) begin
        pv[i] <= pv[i-1];
        pd[i] <= pd[i-1];
      end
      if (o_dram_en && o_dram_we) dmem[slot_of(o_dram_addr)] <= o_dram_wdata;
    end
  end
  assign dram_rdata = pv[RD_LAT-1] ? pd[RD_LAT-1] : 32'hA11C_E0E0;

  task automatic issue(input int m, input logic we, input logic [31:0] addr,
                       input logic [31:0] wdata, input bit push);
    exp_t ex;
    logic bad_a;
    int   s;
    req_d[m] = 1'b1; we_d[m] = we; addr_d[m] = addr; wdata_d[m] = wdata;
    if (push) begin
      bad_a = (addr[1:0] != 2'd0) || ({32'd0, addr} >= 64'(MEM_WORDS) * 64'd4);
      s = slot_of(addr);
      ex.err = bad_a; ex.rd = bad_a || !we; ex.rdata = 32'd0;
      if (!bad_a && we) ref_mem[s] = wdata;
      else if (!bad_a) ex.rdata = ref_mem[s];
      q[m].push_back(ex);
    end
  endtask

  task automatic wait_ack(input int m, output int n);
    n = -1;
    for (int i = 1; i <= 60; i++) begin
      @(negedge clk);
      if ((m == 0) ? o_m0_ack : o_m1_ack) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic run_master(input int m, input int count, input int gapmax, input bit allow_bad);
    int gap, idx, sel, n;
    logic we;
    logic [31:0] addr, w;
    @(negedge clk);
    for (int k = 0; k < count; k++) begin
      gap = $urandom_range(0, gapmax);
      if (gap > 0) begin
        req_d[m] = 1'b0;
        repeat (gap) @(negedge clk);
      end
      we  = 1'($urandom_range(0, 1));
      sel = $urandom_range(0, 7);
      idx = $urandom_range(0, 16);
      if (m == 0) w = (idx == 16) ? 32'd16382 : 32'(idx);
      else        w = (idx == 16) ? 32'd16383 : 32'(32 + idx);
      addr = w << 2;
      if (!we && allow_bad && sel == 0) addr = addr + 32'($urandom_range(1, 3));
      else if (!we && allow_bad && sel == 1) addr = 32'h0001_0000 + 32'($urandom_range(0, 255) * 4);
      issue(m, we, addr, $urandom(), 1'b1);
      wait_ack(m, n);
      check((m == 0) ? "m0_rand_ack_seen" : "m1_rand_ack_seen", n > 0, 1);
      if (n <= 0) break;
    end
    req_d[m] = 1'b0;
  endtask

  task automatic mon_cycle();
    logic a [2];
    logic e [2];
    logic [31:0] r [2];
    exp_t ex;
    a[0] = o_m0_ack; a[1] = o_m1_ack;
    e[0] = o_m0_err; e[1] = o_m1_err;
    r[0] = o_m0_rdata; r[1] = o_m1_rdata;
    check("acks_exclusive", a[0] & a[1], 0);
    for (int m = 0; m < 2; m++) begin
      if (a[m]) begin
        ack_cnt[m]++;
        if (log_en) ack_log.push_back(m);
        check("ack_has_expected", q[m].size() > 0, 1);
        if (q[m].size() > 0) begin
          ex = q[m].pop_front();
          check((m == 0) ? "m0_err" : "m1_err", e[m], ex.err);
          if (ex.rd) mdl_rdata[m] = ex.rdata;
        end
        check((m == 0) ? "m0_rdata" : "m1_rdata", r[m], mdl_rdata[m]);
        check((m == 0) ? "m1_rdata_untouched" : "m0_rdata_untouched", r[1-m], mdl_rdata[1-m]);
      end else begin
        check("err_only_with_ack", e[m], 0);
      end
    end
    if (o_dram_en) begin
      en_cnt++;
      check("dram_addr_legal", (o_dram_addr[1:0] == 2'd0) && (o_dram_addr < 32'h0001_0000), 1);
    end else begin
      check("dram_we_only_with_en", o_dram_we, 0);
    end
  endtask

  // Monitor: pops the scoreboard whenever an ack is presented.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) mon_cycle();
    end
  end

  task automatic check_all_zero(input string name);
    check(name, {o_m0_ack, o_m0_err, o_m1_ack, o_m1_err, o_dram_en, o_dram_we, o_busy, o_cpu_stall}, 0);
    check({name, "_rdata"}, {o_m0_rdata, o_m1_rdata}, 0);
    check({name, "_dram_bus"}, {o_dram_addr, o_dram_wdata}, 0);
  endtask

  task automatic do_reset(input int cycles);
    @(negedge clk);
    rst = 1'b1;
    req_d[0] = 1'b0; req_d[1] = 1'b0;
    q[0].delete(); q[1].delete();
    mdl_rdata[0] = 32'd0; mdl_rdata[1] = 32'd0;
    repeat (cycles) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int n, a0, en0;
    rst = 1'b1;
    for (int m = 0; m < 2; m++) begin
      req_d[m] = 1'b0; we_d[m] = 1'b0; addr_d[m] = 32'd0; wdata_d[m] = 32'd0;
      mdl_rdata[m] = 32'd0; ack_cnt[m] = 0;
    end
    for (int i = 0; i < NSLOT; i++) begin
      dmem[i] = init_word(i);
      ref_mem[i] = init_word(i);
    end
    repeat (3) @(negedge clk);
    check_all_zero("reset_state");
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // M0 write 0x10 <= DEADBEEF: strobe at T+1, ack at T+2, stall covers T..T+1
    issue(0, 1'b1, 32'h10, 32'hDEAD_BEEF, 1'b1);
    #1 check("wr_stall_T", o_cpu_stall, 1);
    @(negedge clk);
    check("wr_dram_strobe_T1", {o_dram_en, o_dram_we}, 2'b11);
    check("wr_dram_addr_T1", o_dram_addr, 32'h10);
    check("wr_dram_wdata_T1", o_dram_wdata, 32'hDEAD_BEEF);
    check("wr_stall_T1", o_cpu_stall, 1);
    @(negedge clk);
    check("wr_ack_T2", o_m0_ack, 1);
    check("wr_stall_T2", o_cpu_stall, 0);
    req_d[0] = 1'b0;
    repeat (2) @(negedge clk);

    // M1 read of its own word, then M0 read of 0x10
    issue(1, 1'b0, 32'h80, 32'd0, 1'b1);
    wait_ack(1, n);
    check("m1_rd_latency", n, 2 + RD_LAT);
    req_d[1] = 1'b0;
    repeat (2) @(negedge clk);
    issue(0, 1'b0, 32'h10, 32'd0, 1'b1);
    wait_ack(0, n);
    check("m0_rd_latency", n, 2 + RD_LAT);
    check("m0_rd_data", o_m0_rdata, 32'hDEAD_BEEF);
    check("m1_rdata_kept", o_m1_rdata, init_word(32));
    req_d[0] = 1'b0;
    repeat (2) @(negedge clk);

    // M1 misaligned and out-of-range reads: immediate err, no DRAM traffic
    en0 = en_cnt;
    issue(1, 1'b0, 32'h3, 32'd0, 1'b1);
    wait_ack(1, n);
    check("err_misaligned_latency", n, 1);
    check("err_misaligned_flags", {o_m1_err, o_m1_rdata}, {1'b1, 32'd0});
    req_d[1] = 1'b0;
    @(negedge clk);
    issue(1, 1'b0, 32'(MEM_WORDS * 4), 32'd0, 1'b1);
    wait_ack(1, n);
    check("err_range_latency", n, 1);
    check("err_range_flags", {o_m1_err, o_m1_rdata}, {1'b1, 32'd0});
    req_d[1] = 1'b0;
    repeat (2) @(negedge clk);
    check("err_no_dram_access", en_cnt - en0, 0);

    // M0 drops req right after grant: one access, one ack
    en0 = en_cnt; a0 = ack_cnt[0];
    issue(0, 1'b1, 32'h14, 32'h1234_5678, 1'b1);
    @(negedge clk);
    req_d[0] = 1'b0;
    wait_ack(0, n);
    check("drop_ack_latency", n, 1);
    repeat (5) @(negedge clk);
    check("drop_single_ack", ack_cnt[0] - a0, 1);
    check("drop_single_access", en_cnt - en0, 1);

    // Reset for two cycles in the middle of an M0 read
    issue(0, 1'b0, 32'h20, 32'd0, 1'b0);
    repeat (3) @(negedge clk);
    rst = 1'b1; req_d[0] = 1'b0;
    q[0].delete(); q[1].delete();
    mdl_rdata[0] = 32'd0; mdl_rdata[1] = 32'd0;
    a0 = ack_cnt[0]; en0 = en_cnt;
    @(negedge clk);
    check_all_zero("midreset_1");
    @(negedge clk);
    check_all_zero("midreset_2");
    rst = 1'b0;
    @(negedge clk);
    check_all_zero("after_reset");
    repeat (6) @(negedge clk);
    check("midreset_no_ack", ack_cnt[0] - a0, 0);
    check("midreset_no_access", en_cnt - en0, 0);

    // Both masters hold req continuously after reset: M0 first, then strict alternation
    do_reset(2);
    ack_log.delete();
    log_en = 1'b1;
    fork
      run_master(0, 4, 0, 1'b0);
      run_master(1, 4, 0, 1'b0);
    join
    log_en = 1'b0;
    check("rr_ack_count", ack_log.size(), 8);
    for (int i = 0; i < ack_log.size(); i++) check("rr_order", ack_log[i], i % 2);
    repeat (3) @(negedge clk);

    // Randomized traffic from both masters
    fork
      run_master(0, 40, 3, 1'b1);
      run_master(1, 40, 3, 1'b1);
    join
    repeat (5) @(negedge clk);
    check("scoreboard_drained", q[0].size() + q[1].size(), 0);
    check("idle_at_end", o_busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got %0d want 0 outstanding", q[0].size() + q[1].size());
    $fatal(1, "timeout");
  end
endmodule
